// File: rtl/tff_chain_ctrl.sv
// tff_chain_ctrl: burst controller driving a synchronous toggle-flop chain.
// A burst issues `len` registered toggle pulses on t; the chain q counts them
// modulo 2^N_STAGES. Bursts can be paused/resumed with stop/start and
// cancelled with abort.
// Optional feature: define TFF_CHAIN_CTRL_WRAP_EN to enable the wrap pulse.
module tff_chain_ctrl #(
    parameter int unsigned N_STAGES = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                abort,
    input  logic [CNT_W-1:0]    len,
    output logic                t,
    output logic [N_STAGES-1:0] q,
    output logic                busy,
    output logic                done,
    output logic                wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                t_q, t_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [N_STAGES-1:0] q_q, q_d;

    // Next-state, toggle enable and remaining-pulse count.
    // t_q is high only in RUN, so every RUN edge consumes one pulse; the
    // pulse being consumed when remaining==1 completes the burst even if
    // stop arrives on that same edge.
    always_comb begin
        state_d = state_q;
        t_d     = 1'b0;
        rem_d   = rem_q;
        if (t_q) begin
            rem_d = rem_q - CNT_W'(1);
        end
        if (abort) begin
            state_d = S_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state_d = S_RUN;
                            rem_d   = len;
                            t_d     = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else if (stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        t_d = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        t_d     = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Toggle chain: stage i toggles when t is high and all lower stages are ones.
    always_comb begin
        logic carry;
        carry = t_q;
        q_d   = q_q;
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            q_d[i] = q_q[i] ^ carry;
            carry  = carry & q_q[i];
        end
        if (abort) begin
            q_d = '0;
        end
    end

    // Controller and chain state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= 1'b0;
            rem_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
        end
    end

`ifdef TFF_CHAIN_CTRL_WRAP_EN
    logic wrap_q, wrap_d;

    // Wrap fires when a t pulse rolls an all-ones chain back to zero.
    always_comb begin
        wrap_d = t_q & (&q_q) & ~abort;
    end

    // Registered wrap pulse, high in the first cycle q reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

    assign t    = t_q;
    assign q    = q_q;
    assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_tff_chain_ctrl.sv
// tb_tff_chain_ctrl: directed vector table plus hand-written multi-cycle
// sequences (pause/resume, wrap, abort, asynchronous reset).
module tb_tff_chain_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        abort;
    logic [15:0] len;
    logic        t;
    logic [3:0]  q;
    logic        busy;
    logic        done;
    logic        wrap;

    int n_cmp = 0;
    int n_err = 0;
    int t_cnt = 0;
    int done_cnt = 0;
    int wrap_cnt = 0;

`ifdef TFF_CHAIN_CTRL_WRAP_EN
    localparam int EXP_WRAP = 1;
`else
    localparam int EXP_WRAP = 0;
`endif

    tff_chain_ctrl #(.N_STAGES(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .abort (abort),
        .len   (len),
        .t     (t),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            t_cnt    = t_cnt + int'(t);
            done_cnt = done_cnt + int'(done);
            wrap_cnt = wrap_cnt + int'(wrap);
        end
    end

    typedef struct {
        logic        start;
        logic        stop;
        logic        abort;
        logic [15:0] len;
        logic        exp_t;
        logic [3:0]  exp_q;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic sp, input logic ab, input logic [15:0] l);
        @(negedge clk);
        start = s;
        stop  = sp;
        abort = ab;
        len   = l;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            step(1'b0, 1'b0, 1'b0, 16'd0);
            if (done) seen = 1'b1;
        end
        chk(name, int'(seen), 1);
    endtask

    initial begin
        int t0, d0, w0;

        // start stop abort len | t q busy done
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd5, 1'b1, 4'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd3, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd4, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'd5, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'd5, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 4'd5, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'd5, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 4'd5, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'd3, 1'b1, 4'd5, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'd9, 1'b1, 4'd6, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 4'd7, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'd8, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 16'd4, 1'b0, 4'd8, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        abort = 1'b0;
        len   = 16'd0;
        #1;
        chk("reset_t", int'(t), 0);
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wrap", int'(wrap), 0);
        repeat (2) @(posedge clk);

        // Table: len=5 burst starting in the first post-reset cycle, len=0,
        // ignored stop/start, continued count from held q, abort clears q.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            start = vecs[i].start;
            stop  = vecs[i].stop;
            abort = vecs[i].abort;
            len   = vecs[i].len;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_t", i), int'(t), int'(vecs[i].exp_t));
            chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].exp_done));
        end

        // Pause after 3 pulses, hold 4 cycles, resume: 10 pulses total.
        t0 = t_cnt;
        d0 = done_cnt;
        step(1'b1, 1'b0, 1'b0, 16'd10);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        chk("pause_t", int'(t), 0);
        chk("pause_q", int'(q), 3);
        chk("pause_busy", int'(busy), 1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 16'd0);
        chk("pause_hold_q", int'(q), 3);
        chk("pause_hold_t", t_cnt - t0, 3);
        step(1'b1, 1'b0, 1'b0, 16'd7);
        chk("resume_t", int'(t), 1);
        wait_done("pause_done_seen", 20);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        chk("pause_total_t", t_cnt - t0, 10);
        chk("pause_final_q", int'(q), 10);
        chk("pause_done_cnt", done_cnt - d0, 1);

        // len=20 from q=0: one wrap after the 16th pulse, final q=4.
        step(1'b0, 1'b0, 1'b1, 16'd0);
        chk("wrap_pre_q", int'(q), 0);
        t0 = t_cnt;
        d0 = done_cnt;
        w0 = wrap_cnt;
        step(1'b1, 1'b0, 1'b0, 16'd20);
        wait_done("wrap_done_seen", 40);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        chk("wrap_total_t", t_cnt - t0, 20);
        chk("wrap_final_q", int'(q), 4);
        chk("wrap_cnt", wrap_cnt - w0, EXP_WRAP);
        chk("wrap_done_cnt", done_cnt - d0, 1);

        // Abort together with stop and start mid-burst.
        d0 = done_cnt;
        step(1'b1, 1'b0, 1'b0, 16'd8);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'd3);
        chk("abort_t", int'(t), 0);
        chk("abort_q", int'(q), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'd0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle_q", int'(q), 0);

        // Asynchronous reset between edges mid-burst, then a full burst.
        d0 = done_cnt;
        step(1'b1, 1'b0, 1'b0, 16'd6);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_t", int'(t), 0);
        chk("arst_q", int'(q), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_wrap", int'(wrap), 0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        chk("arst_no_done", done_cnt - d0, 0);
        t0 = t_cnt;
        d0 = done_cnt;
        step(1'b1, 1'b0, 1'b0, 16'd6);
        chk("post_rst_busy", int'(busy), 1);
        wait_done("post_rst_done_seen", 20);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        chk("post_rst_total_t", t_cnt - t0, 6);
        chk("post_rst_q", int'(q), 6);
        chk("post_rst_done_cnt", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
